// File: rtl/int_alu_seq.sv
// int_alu_seq: sequential RV64/RV32 integer ALU with valid/ready handshake, registered result and tag passthrough.
// Build option: define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module int_alu_seq #(
    parameter int XLEN       = 64,
    parameter int SHIFT_STEP = 8,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_ADDW  = 5'd10;
    localparam logic [4:0] OP_SUBW  = 5'd11;
    localparam logic [4:0] OP_SLLW  = 5'd12;
    localparam logic [4:0] OP_SRLW  = 5'd13;
    localparam logic [4:0] OP_SRAW  = 5'd14;
    localparam logic [4:0] OP_AUIPC = 5'd15;
    localparam logic [4:0] OP_LUI   = 5'd16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifndef ALU_FAST_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [XLEN-1:0] XLEN_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    // Sign-extend a 32-bit value to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // Shift left, logical right or arithmetic right by amt.
    function automatic logic [XLEN-1:0] do_shift(input logic [XLEN-1:0] v, input logic [6:0] amt,
                                                 input logic right, input logic arith);
        logic [XLEN-1:0] r;
        if (right && arith) begin
            r = $signed(v) >>> amt;
        end else if (right) begin
            r = v >> amt;
        end else begin
            r = v << amt;
        end
        return r;
    endfunction

    // W results keep only the low word, sign-extended.
    function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] v, input logic word);
        logic [XLEN-1:0] r;
        if (word) begin
            r = sext32(v[31:0]);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [XLEN-1:0]  result_r;
    logic [TAG_W-1:0] tag_r;
    logic             illegal_r;

    logic             legal_s;
    logic             is_shift_s;
    logic             is_right_s;
    logic             is_arith_s;
    logic             is_w_s;
    logic [XLEN-1:0]  base_res_s;
    logic [6:0]       shamt_s;
    logic [XLEN-1:0]  prep_s;
    logic [XLEN-1:0]  shift_res_s;
    logic [XLEN-1:0]  alu_res_s;
    logic             accept_s;

    assign in_ready    = (state_r == ST_IDLE) | ((state_r == ST_HOLD) & out_ready);
    assign out_valid   = (state_r == ST_HOLD);
    assign out_result  = result_r;
    assign out_tag     = tag_r;
    assign out_illegal = illegal_r;
    assign accept_s    = in_valid & in_ready;

    // Decode the offered op and compute every non-shift result.
    always_comb begin
        legal_s    = 1'b1;
        is_shift_s = 1'b0;
        is_right_s = 1'b0;
        is_arith_s = 1'b0;
        is_w_s     = 1'b0;
        base_res_s = '0;
        case (in_op)
            OP_ADD:   base_res_s = in_op1 + in_op2;
            OP_SUB:   base_res_s = in_op1 + ~in_op2 + XLEN_ONE;
            OP_SLL:   is_shift_s = 1'b1;
            OP_SLT:   base_res_s = {{(XLEN-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
            OP_SLTU:  base_res_s = {{(XLEN-1){1'b0}}, (in_op1 < in_op2)};
            OP_XOR:   base_res_s = in_op1 ^ in_op2;
            OP_SRL: begin
                is_shift_s = 1'b1;
                is_right_s = 1'b1;
            end
            OP_SRA: begin
                is_shift_s = 1'b1;
                is_right_s = 1'b1;
                is_arith_s = 1'b1;
            end
            OP_OR:    base_res_s = in_op1 | in_op2;
            OP_AND:   base_res_s = in_op1 & in_op2;
            OP_ADDW: begin
                is_w_s     = 1'b1;
                base_res_s = sext32(in_op1[31:0] + in_op2[31:0]);
            end
            OP_SUBW: begin
                is_w_s     = 1'b1;
                base_res_s = sext32(in_op1[31:0] + ~in_op2[31:0] + 32'd1);
            end
            OP_SLLW: begin
                is_w_s     = 1'b1;
                is_shift_s = 1'b1;
            end
            OP_SRLW: begin
                is_w_s     = 1'b1;
                is_shift_s = 1'b1;
                is_right_s = 1'b1;
            end
            OP_SRAW: begin
                is_w_s     = 1'b1;
                is_shift_s = 1'b1;
                is_right_s = 1'b1;
                is_arith_s = 1'b1;
            end
            OP_AUIPC: base_res_s = in_op1 + sext32({in_op2[19:0], 12'h000});
            OP_LUI:   base_res_s = sext32({in_op2[19:0], 12'h000});
            default:  legal_s    = 1'b0;
        endcase
        // W ops do not exist on a 32-bit datapath.
        legal_s    = legal_s & ~(is_w_s & (XLEN != 64));
        is_shift_s = is_shift_s & legal_s;
    end

    // Shift operand preparation and final result selection.
    always_comb begin
        shamt_s = (is_w_s || (XLEN != 64)) ? {2'b00, in_op2[4:0]} : {1'b0, in_op2[5:0]};
        prep_s  = in_op1;
        // A W operand is widened so a full-width shift leaves the correct low word.
        if (is_w_s) begin
            if (is_arith_s) begin
                prep_s = sext32(in_op1[31:0]);
            end else begin
                prep_s       = '0;
                prep_s[31:0] = in_op1[31:0];
            end
        end else begin
            prep_s = in_op1;
        end
`ifdef ALU_FAST_SHIFT_EN
        shift_res_s = finalize(do_shift(prep_s, shamt_s, is_right_s, is_arith_s), is_w_s);
`else
        shift_res_s = finalize(prep_s, is_w_s);
`endif
        if (!legal_s) begin
            alu_res_s = '0;
        end else if (is_shift_s) begin
            alu_res_s = shift_res_s;
        end else begin
            alu_res_s = base_res_s;
        end
    end

`ifndef ALU_FAST_SHIFT_EN
    localparam logic [6:0] STEP_C = 7'(SHIFT_STEP);

    logic [XLEN-1:0] shreg_r;
    logic [6:0]      rem_r;
    logic            right_r;
    logic            arith_r;
    logic            word_r;
    logic [6:0]      step_s;
    logic [XLEN-1:0] step_res_s;
    logic            start_shift_s;

    assign start_shift_s = accept_s & is_shift_s & (shamt_s != 7'd0);

    // One iteration of the shifter: at most SHIFT_STEP positions.
    always_comb begin
        if (rem_r > STEP_C) begin
            step_s = STEP_C;
        end else begin
            step_s = rem_r;
        end
        step_res_s = do_shift(shreg_r, step_s, right_r, arith_r);
    end

    // Iterative shifter working register and remaining-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= '0;
            rem_r   <= 7'd0;
            right_r <= 1'b0;
            arith_r <= 1'b0;
            word_r  <= 1'b0;
        end else if (start_shift_s) begin
            shreg_r <= prep_s;
            rem_r   <= shamt_s;
            right_r <= is_right_s;
            arith_r <= is_arith_s;
            word_r  <= is_w_s;
        end else if (state_r == ST_SHIFT) begin
            shreg_r <= step_res_s;
            rem_r   <= rem_r - step_s;
        end
    end
`endif

    // Handshake state machine and registered result/tag/illegal outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            result_r  <= '0;
            tag_r     <= '0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s) begin
                        tag_r     <= in_tag;
                        illegal_r <= ~legal_s;
`ifdef ALU_FAST_SHIFT_EN
                        state_r   <= ST_HOLD;
                        result_r  <= alu_res_s;
`else
                        if (start_shift_s) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r  <= ST_HOLD;
                            result_r <= alu_res_s;
                        end
`endif
                    end else if ((state_r == ST_HOLD) && out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                ST_SHIFT: begin
                    if (rem_r == step_s) begin
                        state_r  <= ST_HOLD;
                        result_r <= finalize(step_res_s, word_r);
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
`endif
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
